// File: rtl/p_addsub_arb.sv
// p_addsub_arb: two-port round-robin sequencer that issues 64-bit packed add/sub ops as two 32-bit halves.
// Optional P_ADDSUB_ARB_PIPE_EN: arbitrate during the response handshake for one request per 3 cycles.
module p_addsub_arb #(
   parameter  logic CEN  = 1'b1,
   localparam int   NREQ = 2
) (
   input  logic                 g_clk,
   input  logic                 g_resetn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [64*NREQ-1:0]   req_lhs,
   input  logic [64*NREQ-1:0]   req_rhs,
   input  logic [5*NREQ-1:0]    req_pw,
   input  logic [NREQ-1:0]      req_sub,
   input  logic [NREQ-1:0]      req_wide,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [63:0]          rsp_result,
   output logic                 rsp_carry,
   output logic [31:0]          au_lhs,
   output logic [31:0]          au_rhs,
   output logic [4:0]           au_pw,
   output logic                 au_cin,
   output logic                 au_sub,
   output logic                 au_c_en,
   input  logic [31:0]          au_result,
   input  logic [32:0]          au_c_out
);
   // state | meaning
   // IDLE  | arbitrating between requesters, nothing held
   // LO    | low half of the held request on the datapath
   // HI    | high half on the datapath, carry-chained for wide 32-bit ops
   // RSP   | response presented and held until rsp_ready
   typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

   state_t      state;
   logic        last_grant;
   logic [63:0] lhs_q;
   logic [63:0] rhs_q;
   logic [4:0]  pw_q;
   logic        sub_q;
   logic        wide_q;
   logic        arb_en;
   logic        grant_any;
   logic        grant_id;
   logic        chain;
   logic        unused_c_out;

   assign unused_c_out = ^au_c_out[31:0];

`ifdef P_ADDSUB_ARB_PIPE_EN
   assign arb_en = (state == IDLE) || ((state == RSP) && rsp_ready);
`else
   assign arb_en = (state == IDLE);
`endif

   // Round-robin: on a tie the port that did not win last time goes next.
   always_comb begin
      grant_id = req_valid[1];
      if (&req_valid) grant_id = ~last_grant;
   end

   assign grant_any = arb_en && (|req_valid);
   assign req_ready = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign chain     = wide_q && (pw_q == 5'b00001);

   // The chained high half runs as an add: the low half already applied the +1 of two's complement.
   always_comb begin
      au_lhs  = '0;
      au_rhs  = '0;
      au_pw   = '0;
      au_cin  = 1'b0;
      au_sub  = 1'b0;
      au_c_en = CEN;
      case (state)
         LO: begin
            au_lhs = lhs_q[31:0];
            au_rhs = rhs_q[31:0];
            au_pw  = pw_q;
            au_sub = sub_q;
         end
         HI: begin
            au_lhs = lhs_q[63:32];
            au_pw  = pw_q;
            if (chain) begin
               au_rhs = sub_q ? ~rhs_q[63:32] : rhs_q[63:32];
               au_cin = rsp_carry;
            end else begin
               au_rhs = rhs_q[63:32];
               au_sub = sub_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         lhs_q      <= '0;
         rhs_q      <= '0;
         pw_q       <= '0;
         sub_q      <= 1'b0;
         wide_q     <= 1'b0;
      end else begin
         if (grant_any) begin
            lhs_q      <= req_lhs[64*grant_id +: 64];
            rhs_q      <= req_rhs[64*grant_id +: 64];
            pw_q       <= req_pw[5*grant_id +: 5];
            sub_q      <= req_sub[grant_id];
            wide_q     <= req_wide[grant_id];
            rsp_id     <= grant_id;
            last_grant <= grant_id;
         end
         case (state)
            IDLE: begin
               if (grant_any) state <= LO;
            end
            LO: begin
               rsp_result[31:0] <= au_result;
               rsp_carry        <= au_c_out[32];
               state            <= HI;
            end
            HI: begin
               rsp_result[63:32] <= au_result;
               rsp_carry         <= au_c_out[32];
               rsp_valid         <= 1'b1;
               state             <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= grant_any ? LO : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
